channel_scheduler: RTL

Command sequencer between the UART command decoder and the bank of serial-out channels. On each decoded command it loads one channel's pattern/frequency, issues start/stop, tracks busy state, auto-restarts continuous-mode channels, and returns a one-byte acknowledge to the UART transmitter.

---
 rtl/channel_scheduler.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/channel_scheduler.sv
// Command sequencer between the UART command decoder and the serial-out channel bank:
// loads/starts/stops one channel per command, tracks busy/continuous state, returns an ack byte.
module channel_scheduler #(
   parameter int DATA_BIT = 32,
   parameter int CH_NUM   = 16
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                i_cmd_tick,
   input  logic [DATA_BIT-1:0] i_output_pattern,
   input  logic [DATA_BIT-1:0] i_freq_pattern,
   input  logic [3:0]          i_sel,
   input  logic                i_start,
   input  logic                i_stop,
   input  logic                i_mode,
   input  logic [CH_NUM-1:0]   i_ch_done,
   input  logic                i_tx_done_tick,
   output logic                o_load_tick,
   output logic [3:0]          o_load_sel,
   output logic [DATA_BIT-1:0] o_pattern,
   output logic [DATA_BIT-1:0] o_freq,
   output logic [CH_NUM-1:0]   o_start_vec,
   output logic [CH_NUM-1:0]   o_stop_vec,
   output logic [CH_NUM-1:0]   o_busy_vec,
   output logic [7:0]          o_tx_data,
   output logic                o_tx_start,
   output logic                o_overflow
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_CMD     = 3'd2,
      S_ACK     = 3'd3,
      S_WAIT_TX = 3'd4
   } state_t;

   localparam logic [4:0] CH_LIM = 5'(CH_NUM);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [3:0]          r_sel;
   logic                r_start;
   logic                r_stop;
   logic                r_mode;
   logic                r_load_tick;
   logic [3:0]          r_load_sel;
   logic [DATA_BIT-1:0] r_pattern;
   logic [DATA_BIT-1:0] r_freq;
   logic [CH_NUM-1:0]   r_start_vec;
   logic [CH_NUM-1:0]   r_stop_vec;
   logic [CH_NUM-1:0]   r_busy;
   logic [CH_NUM-1:0]   r_cont;
   logic [7:0]          r_tx_data;
   logic                r_tx_start;
   logic                r_overflow;

   logic                w_accept;
   logic                w_in_ok;
   logic                w_load;
   logic                w_sel_ok;
   logic                w_do_cmd;
   logic [3:0]          w_status;
   logic [CH_NUM-1:0]   w_sel_oh;
   logic [CH_NUM-1:0]   w_cmd_start_oh;
   logic [CH_NUM-1:0]   w_cmd_stop_oh;
   logic [CH_NUM-1:0]   w_done_v;
   logic [CH_NUM-1:0]   w_restart;
   logic [CH_NUM-1:0]   w_busy_nxt;
   logic [CH_NUM-1:0]   w_cont_nxt;

   assign w_accept = (r_state == S_IDLE) && i_cmd_tick;
   assign w_in_ok  = ({1'b0, i_sel} < CH_LIM);
   assign w_load   = w_accept && w_in_ok && !i_stop;
   assign w_sel_ok = ({1'b0, r_sel} < CH_LIM);
   assign w_do_cmd = (r_state == S_LOAD) && w_sel_ok;

   // One-hot decode of the captured channel select.
   always_comb begin
      w_sel_oh = '0;
      for (int k = 0; k < CH_NUM; k++) begin
         w_sel_oh[k] = (r_sel == 4'(k));
      end
   end

   // Acknowledge status nibble, derived purely from the captured command.
   always_comb begin
      w_status = 4'h2;
      if (!w_sel_ok) begin
         w_status = 4'hE;
      end else if (r_stop) begin
         w_status = 4'h1;
      end else if (r_start) begin
         w_status = 4'h0;
      end else begin
         w_status = 4'h2;
      end
   end

   // Per-channel bookkeeping; a stop on k suppresses any restart for k in the same cycle.
   always_comb begin
      w_cmd_stop_oh  = (w_do_cmd && r_stop) ? w_sel_oh : '0;
      w_cmd_start_oh = (w_do_cmd && !r_stop && r_start) ? w_sel_oh : '0;
      w_done_v       = i_ch_done & r_busy;
      w_restart      = w_done_v & r_cont & ~w_cmd_stop_oh;
      w_busy_nxt     = ((r_busy & ~(w_done_v & ~r_cont)) & ~w_cmd_stop_oh) | w_cmd_start_oh;
      w_cont_nxt     = (r_cont & ~w_cmd_stop_oh & ~w_cmd_start_oh)
                     | (w_cmd_start_oh & {CH_NUM{r_mode}});
   end

   // Command sequencing next-state logic.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_cmd_tick) begin
               w_state_nxt = S_LOAD;
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_LOAD: begin
            if (w_sel_ok) begin
               w_state_nxt = S_CMD;
            end else begin
               w_state_nxt = S_ACK;
            end
         end
         S_CMD:   w_state_nxt = S_ACK;
         S_ACK:   w_state_nxt = S_WAIT_TX;
         S_WAIT_TX: begin
            if (i_tx_done_tick) begin
               w_state_nxt = S_IDLE;
            end else begin
               w_state_nxt = S_WAIT_TX;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // State, command capture, channel status and registered output pulses.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_sel       <= 4'd0;
         r_start     <= 1'b0;
         r_stop      <= 1'b0;
         r_mode      <= 1'b0;
         r_load_tick <= 1'b0;
         r_load_sel  <= 4'd0;
         r_pattern   <= '0;
         r_freq      <= '0;
         r_start_vec <= '0;
         r_stop_vec  <= '0;
         r_busy      <= '0;
         r_cont      <= '0;
         r_tx_data   <= 8'd0;
         r_tx_start  <= 1'b0;
         r_overflow  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_accept) begin
            r_sel   <= i_sel;
            r_start <= i_start;
            r_stop  <= i_stop;
            r_mode  <= i_mode;
         end
         r_load_tick <= w_load;
         r_load_sel  <= w_load ? i_sel : 4'd0;
         r_pattern   <= w_load ? i_output_pattern : '0;
         r_freq      <= w_load ? i_freq_pattern : '0;
         r_start_vec <= w_cmd_start_oh | w_restart;
         r_stop_vec  <= w_cmd_stop_oh;
         r_busy      <= w_busy_nxt;
         r_cont      <= w_cont_nxt;
         r_tx_start  <= (w_state_nxt == S_ACK);
         if (w_state_nxt == S_ACK) begin
            r_tx_data <= {w_status, r_sel};
         end
         r_overflow <= r_overflow | (i_cmd_tick && (r_state != S_IDLE));
      end
   end

   assign o_load_tick = r_load_tick;
   assign o_load_sel  = r_load_sel;
   assign o_pattern   = r_pattern;
   assign o_freq      = r_freq;
   assign o_start_vec = r_start_vec;
   assign o_stop_vec  = r_stop_vec;
   assign o_busy_vec  = r_busy;
   assign o_tx_data   = r_tx_data;
   assign o_tx_start  = r_tx_start;
   assign o_overflow  = r_overflow;

endmodule
